// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter
package mem_arb_pkg;
  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;
  localparam logic [2:0] MEM_TYPE_WORD = 3'b010;
  typedef enum logic [1:0] {IDLE, I_WAIT, D_WAIT, RESP} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;
endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: counts data grants taken while fetch waits and raises o_force at LIMIT
//   clk, rst       clock, synchronous active-high reset
//   i_if_req       fetch request pending
//   i_data_acc     data transaction accepted this cycle
//   i_fetch_acc    fetch transaction accepted this cycle
//   o_force        fetch must win the next selection
module arb_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_if_req,
  input  logic i_data_acc,
  input  logic i_fetch_acc,
  output logic o_force
);
  localparam int CW = $clog2(LIMIT + 1);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (rst || i_fetch_acc || !i_if_req) r_cnt <= '0;
    else if (i_data_acc && r_cnt != CW'(LIMIT)) r_cnt <= r_cnt + 1'b1;
  end
  assign o_force = r_cnt == CW'(LIMIT);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory between fetch and load/store ports
//   CLK, Reset                    clock, synchronous active-high reset
//   if_req/if_addr -> if_rdata/if_valid              fetch port
//   d_rd_en/d_wr_en/d_addr/d_wdata/d_type -> d_rdata/d_valid   data port
//   mem_req/mem_we/mem_addr/mem_wdata/mem_type, mem_ready/mem_rvalid/mem_rdata   memory side
//   cpu_stall                     pipeline stall while any request is outstanding
//   Define ARB_STARVE_EN to force fetch after STARVE_LIMIT data grants with fetch pending.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
`ifdef ARB_STARVE_EN
  , parameter int STARVE_LIMIT = 4
`endif
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          d_rd_en,
  input  logic          d_wr_en,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [2:0]    d_type,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [2:0]    mem_type,
  input  logic          mem_ready,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          cpu_stall
);
  state_t        r_state;
  owner_t        r_owner;
  logic          r_we;
  logic [DW-1:0] r_if_rdata, r_d_rdata;
  logic          w_d_req, w_force, w_sel_d, w_sel_i, w_acc;
`ifdef ARB_STARVE_EN
  logic w_force_raw;
  arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk        (CLK),
    .rst        (Reset),
    .i_if_req   (if_req),
    .i_data_acc (w_acc & w_sel_d),
    .i_fetch_acc(w_acc & w_sel_i),
    .o_force    (w_force_raw)
  );
  // forcing only matters while fetch is actually asking, otherwise data would idle
  assign w_force = w_force_raw & if_req;
`else
  assign w_force = 1'b0;
`endif
  assign w_d_req   = d_rd_en | d_wr_en;
  assign w_sel_d   = w_d_req & ~w_force;
  assign w_sel_i   = if_req & ~w_sel_d;
  assign mem_req   = ~Reset & (r_state == IDLE) & (w_sel_d | w_sel_i);
  assign mem_we    = mem_req & w_sel_d & d_wr_en;
  assign mem_addr  = w_sel_d ? d_addr : if_addr;
  assign mem_wdata = d_wdata;
  assign mem_type  = w_sel_d ? d_type : MEM_TYPE_WORD;
  assign w_acc     = mem_req & mem_ready;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign if_valid  = (r_state == RESP) & (r_owner == OWN_I);
  assign d_valid   = (r_state == RESP) & (r_owner == OWN_D);
  assign cpu_stall = ~Reset & ((if_req & ~if_valid) | (w_d_req & ~d_valid));
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_owner    <= OWN_I;
      r_we       <= 1'b0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_acc) begin
          r_state <= w_sel_d ? D_WAIT : I_WAIT;
          r_owner <= w_sel_d ? OWN_D : OWN_I;
          r_we    <= mem_we;
        end
        I_WAIT: if (mem_rvalid) begin
          r_state    <= RESP;
          r_if_rdata <= mem_rdata;
        end
        D_WAIT: if (mem_rvalid) begin
          r_state <= RESP;
          if (!r_we) r_d_rdata <= mem_rdata;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        if_req = 0, if_valid, d_rd_en = 0, d_wr_en = 0, d_valid;
  logic [31:0] if_addr = 0, if_rdata, d_addr = 0, d_wdata = 0, d_rdata;
  logic [2:0]  d_type = 3'b010, mem_type;
  logic        mem_req, mem_we, mem_ready = 0, mem_rvalid = 0, cpu_stall;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
  int n_chk = 0, n_fail = 0;
`ifdef ARB_STARVE_EN
  localparam int FORCE_AT = 4;
`else
  localparam int FORCE_AT = -1;
`endif

  mem_port_arbiter dut (
    .CLK(clk), .Reset(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_rd_en(d_rd_en), .d_wr_en(d_wr_en), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_type(d_type), .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_type(mem_type), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .cpu_stall(cpu_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    if_req = 1;
    cyc(); cyc();
    chk("rst_stall", {31'd0, cpu_stall}, 0);
    chk("rst_mem_req", {31'd0, mem_req}, 0);
    chk("rst_ifv", {31'd0, if_valid}, 0);
    chk("rst_dv", {31'd0, d_valid}, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    rst = 0;
    // fetch only, single-cycle memory
    if_addr = 32'h100; mem_ready = 1; #1;
    chk("f_req", {31'd0, mem_req}, 1);
    chk("f_addr", mem_addr, 32'h100);
    chk("f_type", {29'd0, mem_type}, 32'h2);
    chk("f_we", {31'd0, mem_we}, 0);
    chk("f_stall0", {31'd0, cpu_stall}, 1);
    cyc();
    mem_rvalid = 1; mem_rdata = 32'h13; #1;
    chk("f_req_wait", {31'd0, mem_req}, 0);
    chk("f_stall1", {31'd0, cpu_stall}, 1);
    cyc();
    mem_rvalid = 0;
    chk("f_valid", {31'd0, if_valid}, 1);
    chk("f_rdata", if_rdata, 32'h13);
    chk("f_stall2", {31'd0, cpu_stall}, 0);
    chk("f_req_resp", {31'd0, mem_req}, 0);
    if_req = 0;
    cyc();
    chk("f_valid_drop", {31'd0, if_valid}, 0);
    // simultaneous fetch and load
    if_req = 1; if_addr = 32'h104; d_rd_en = 1; d_addr = 32'h2000; d_type = 3'b010; #1;
    chk("s_addr", mem_addr, 32'h2000);
    chk("s_we", {31'd0, mem_we}, 0);
    cyc();
    mem_rvalid = 1; mem_rdata = 32'h11223344;
    cyc();
    mem_rvalid = 0;
    chk("s_dvalid", {31'd0, d_valid}, 1);
    chk("s_ifvalid", {31'd0, if_valid}, 0);
    chk("s_drdata", d_rdata, 32'h11223344);
    chk("s_stall", {31'd0, cpu_stall}, 1);
    d_rd_en = 0;
    cyc();
    chk("s_f_req", {31'd0, mem_req}, 1);
    chk("s_f_addr", mem_addr, 32'h104);
    cyc();
    mem_rvalid = 1; mem_rdata = 32'h33;
    cyc();
    mem_rvalid = 0;
    chk("s_f_valid", {31'd0, if_valid}, 1);
    chk("s_f_rdata", if_rdata, 32'h33);
    if_req = 0;
    cyc();
    // store with memory back-pressure
    mem_ready = 0; d_wr_en = 1; d_addr = 32'h3000; d_wdata = 32'hDEADBEEF; d_type = 3'b001;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) mem_ready = 1;
      #1;
      chk("w_req", {31'd0, mem_req}, 1);
      chk("w_we", {31'd0, mem_we}, 1);
      chk("w_addr", mem_addr, 32'h3000);
      chk("w_wdata", mem_wdata, 32'hDEADBEEF);
      chk("w_type", {29'd0, mem_type}, 32'h1);
      chk("w_dvalid_pre", {31'd0, d_valid}, 0);
      cyc();
    end
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'hFFFFFFFF;
    cyc();
    mem_rvalid = 0;
    chk("w_dvalid", {31'd0, d_valid}, 1);
    chk("w_drdata_keep", d_rdata, 32'h11223344);
    d_wr_en = 0;
    cyc();
    // reset while waiting on a load
    mem_ready = 1; d_rd_en = 1; d_addr = 32'h4000; d_type = 3'b010;
    cyc();
    rst = 1; mem_ready = 0; #1;
    chk("r_stall_in_rst", {31'd0, cpu_stall}, 0);
    cyc();
    rst = 0; d_rd_en = 0; mem_rvalid = 1; mem_rdata = 32'h55; #1;
    chk("r_req", {31'd0, mem_req}, 0);
    chk("r_dvalid", {31'd0, d_valid}, 0);
    chk("r_drdata", d_rdata, 0);
    chk("r_ifrdata", if_rdata, 0);
    chk("r_stall", {31'd0, cpu_stall}, 0);
    cyc();
    mem_rvalid = 0;
    chk("r_dvalid_late", {31'd0, d_valid}, 0);
    chk("r_drdata_late", d_rdata, 0);
    // back-to-back loads with fetch held
    if_req = 1; if_addr = 32'h200; d_rd_en = 1; d_addr = 32'h5000;
    for (int i = 0; i < 6; i++) begin
      if (i <= FORCE_AT || FORCE_AT < 0) begin
        mem_ready = 1; #1;
        chk("st_addr", mem_addr, (i == FORCE_AT) ? 32'h200 : 32'h5000);
        cyc();
        mem_ready = 0; mem_rvalid = 1; mem_rdata = i;
        cyc();
        mem_rvalid = 0;
        chk("st_dvalid", {31'd0, d_valid}, (i == FORCE_AT) ? 0 : 1);
        chk("st_ifvalid", {31'd0, if_valid}, (i == FORCE_AT) ? 1 : 0);
        cyc();
      end
    end
    if_req = 0; d_rd_en = 0;
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, variable-latency memory between the CPU's instruction-fetch port and its load/store port. Sits between the three-stage RV32 core and the unified memory: issues at most one memory transaction at a time, returns read data to the owning requester, and drives a stall to the pipeline while any request is outstanding. Data accesses win over fetch; an optional anti-starvation counter guarantees fetch progress.

## Interface
- AW, 32, address width
- DW, 32, data width
- STARVE_LIMIT, 4, consecutive data grants with fetch pending before fetch is forced (used only with ARB_STARVE_EN)

- CLK  in  1  clock, all state on rising edge
- Reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, held until if_valid
- if_addr  in  AW  fetch address
- if_rdata  out  DW  fetched instruction, registered
- if_valid  out  1  one-cycle fetch completion pulse
- d_rd_en / d_wr_en  in  1 / 1  load / store request, held until d_valid; never both
- d_addr, d_wdata  in  AW, DW  data address, store data
- d_type  in  3  transfer size code, passed through unchanged
- d_rdata  out  DW  load data, registered
- d_valid  out  1  one-cycle data completion pulse (loads and stores)
- mem_req  out  1  memory request
- mem_we  out  1  write strobe, valid with mem_req
- mem_addr, mem_wdata  out  AW, DW  muxed address / write data
- mem_type  out  3  size code (d_type for data, 3'b010 for fetch)
- mem_ready  in  1  memory accepts request this cycle
- mem_rvalid  in  1  response (read data or write ack), ≥1 cycle after acceptance
- mem_rdata  in  DW  read data, valid with mem_rvalid
- cpu_stall  out  1  pipeline stall

## Operation
- States: IDLE, I_WAIT, D_WAIT, RESP.
- IDLE: selection = data if (d_rd_en|d_wr_en) and not forced-fetch; else fetch if if_req. mem_req=1 with selected fields. On mem_req&mem_ready → I_WAIT or D_WAIT per owner. No request or mem_ready=0 → stay; selection re-evaluated every cycle (no lock before acceptance).
- I_WAIT/D_WAIT: mem_req=0. On mem_rvalid: capture mem_rdata into owner's rdata register (stores: d_rdata unchanged), → RESP.
- RESP: owner's valid=1 for exactly this cycle; → IDLE. No issue in RESP.
- mem_rvalid outside I_WAIT/D_WAIT ignored.
- cpu_stall = (if_req & ~if_valid) | ((d_rd_en|d_wr_en) & ~d_valid), combinational; forced 0 while Reset.
- mem_* outputs combinational from state and selection; mem_req=0, mem_we=0 outside IDLE.

## Timing
- Reset: state IDLE, mem_req 0, if_valid/d_valid 0, if_rdata/d_rdata 0, starve count 0, cpu_stall 0.
- Accept at cycle 0, mem_rvalid at cycle k (k≥1) → valid at k+1, next mem_req earliest k+2.
- Single-cycle memory (mem_ready=1, k=1): one transaction per 3 cycles.
- Simultaneous fetch and data in IDLE: data accepted first, fetch issued in the following IDLE.
- Reset mid-transaction: abandon, return IDLE next edge, no valid pulse; late mem_rvalid ignored.

## Configuration
- ARB_STARVE_EN defined: counter increments on each data acceptance while if_req=1, clears on fetch acceptance or if_req=0; at count==STARVE_LIMIT, IDLE selects fetch even if data pending. Counter saturates at STARVE_LIMIT.
- Undefined: strict data priority, no counter logic.

## Structure
- Package mem_arb_pkg: state enum (IDLE, I_WAIT, D_WAIT, RESP), owner enum, MEM_TYPE_WORD = 3'b010, AW/DW defaults.
- One sub-module: arb_starve_ctr (count, saturate, force_fetch output), instantiated only under ARB_STARVE_EN.

## Test plan
- Fetch only, if_addr=0x100, mem_ready=1, rvalid one cycle after accept with 0x00000013 → if_valid at cycle 2, if_rdata=0x00000013, cpu_stall 1 in cycles 0–1, 0 in cycle 2.
- Simultaneous if_req (0x104) and d_rd_en (0x2000, d_type=3'b010) → data accepted first, d_rdata=mem_rdata; fetch mem_req at cycle 3.
- Store d_wr_en, addr 0x3000, wdata 0xDEADBEEF, mem_ready low 2 cycles → mem_req held with stable fields, mem_we=1 on acceptance, d_valid after ack.
- Reset asserted in D_WAIT, then mem_rvalid=1 → no d_valid, state IDLE, all outputs at reset values.
- ARB_STARVE_EN, STARVE_LIMIT=4, data requests back-to-back with if_req held → fetch accepted after 4th data completion; undefined → fetch never issued while data pending.
